lsu_rmw: RTL
============

// Module: lsu_rmw
// PURPOSE
//  Load/store unit between the core datapath and the word-only unified memory.
//  The memory reads combinationally on address bits [31:2] and writes one whole
//  32-bit word on the clock edge when its write enable is high.
//  This block turns RV32I byte/half/word loads and stores into word accesses.
//  Sub-word stores use a read-modify-write sequence.
//  Loads are returned lane-selected and sign- or zero-extended, with a busy/done handshake to the core FSM.
// PARAMETERS
//  MEM_WORDS    16000  number of 32-bit words in the memory; a word index >= MEM_WORDS is an error
//  CHECK_RANGE  1      1: enable the out-of-range check; 0: no range check
// PORTS
//  clk       in   1   clock; all state changes on the rising edge
//  rst       in   1   synchronous, active-high reset
//  req       in   1   start an access; accepted only when busy=0
//  we_req    in   1   1=store, 0=load (sampled with req)
//  funct3    in   3   RV32I width: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
//  addr      in   32  byte address (sampled with req)
//  wdata     in   32  store data (sampled with req)
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse that ends an access
//  err       out  1   pulse coincident with done: misaligned, illegal funct3 or out-of-range
//  rdata     out  32  load result; valid while done=1, held until the next accepted req
//  mem_addr  out  32  {addr_q[31:2],2'b00}
//  mem_wd    out  32  merged write word; 0 outside the WRITE state
//  mem_we    out  1   high only in the WRITE state
//  mem_rd    in   32  combinational read data from the memory
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, mem_we, mem_wd, rdata and all latched regs = 0.
//  Reset sampled in any state aborts the access:
//   - IDLE next cycle, no done pulse;
//   - a WRITE in the same cycle is dropped (the memory's own reset wins).
//  Accept: in IDLE with req=1, latch addr_q/wdata_q/f3_q/we_q at the edge.
//  req while busy=1 is ignored, not queued.
//  Error check runs at accept. Error cases:
//   - funct3 in {011,110,111};
//   - store with funct3[2]=1;
//   - h access with addr[0]=1;
//   - w access with addr[1:0]!=0;
//   - CHECK_RANGE=1 and addr[31:2] >= MEM_WORDS.
//  On error: IDLE->ERR, then done=err=1 for 1 cycle, then IDLE. No memory write; rdata unchanged.
//  FSM paths:
//   - load:         IDLE -> READ -> DONE -> IDLE
//   - store word:   IDLE -> WRITE -> DONE -> IDLE
//   - store b/h:    IDLE -> READ -> WRITE -> DONE -> IDLE
//  READ: capture mem_rd into word_q at the end of the cycle.
//  WRITE: mem_we=1, mem_wd = merged word:
//   - sb replaces byte lane addr_q[1:0] with wdata_q[7:0];
//   - sh replaces half lane addr_q[1] with wdata_q[15:0];
//   - sw writes wdata_q.
//  Load extract (computed from mem_rd in READ, registered into rdata):
//   - lb/lbu: byte at lane addr_q[1:0], sign-/zero-extended;
//   - lh/lhu: half at lane addr_q[1], sign-/zero-extended;
//   - lw: the full word.
//  Latency (req edge = cycle 0): done is high in
//   - cycle 2 for loads and sw;
//   - cycle 3 for sb/sh;
//   - cycle 1 for errors.
//  done and err are registered-state decodes (DONE/ERR states); never high in IDLE.
//  A new req is accepted in the cycle after done (back-to-back throughput: 3/4 cycles).
// TESTING
//  1. mem[4]=0x11223344; sb addr=0x12 wdata=0xAA -> mem_we once in cycle 2, mem[4]=0x11AA3344, done in cycle 3.
//  2. mem[4]=0x8000F0F0; lb 0x13 -> rdata=0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x10 -> 0xFFFFF0F0; lhu 0x12 -> 0x00008000.
//  3. sw addr=0x20 wdata=0xDEADBEEF -> no READ state, mem_we high in cycle 1, done in cycle 2, mem[8]=0xDEADBEEF.
//  4. Error cases -> done=err=1 in cycle 1, mem_we never high, rdata unchanged:
//     lw addr=0x22; sh addr=0x21; store funct3=100; lw addr=64000 with MEM_WORDS=16000.
//  5. rst=1 in the WRITE cycle of sb -> mem_we low after the reset edge, no done, busy=0 next cycle, a new req is accepted.
//  6. req held high continuously with alternating load/store -> each accepted only in IDLE,
//     exactly one done per access, no ignored-req side effects.

Source files
------------

// File: rtl/lsu_rmw.sv
// Load/store unit: turns RV32I b/h/w loads and stores into whole-word
// accesses on a word-only memory. Sub-word stores read, merge, then write.
module lsu_rmw #(
    parameter int unsigned MEM_WORDS   = 16000,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Request fields latched at accept.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        we;
    } req_t;

    state_t      state_q, state_d;
    req_t        rq_q, rq_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        acc_err;
    logic [31:0] merged;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Accept decode and the error check on the incoming request.
    always_comb begin
        accept  = (state_q == S_IDLE) && req;
        acc_err = 1'b0;
        case (funct3)
            3'b011, 3'b110, 3'b111: acc_err = 1'b1;
            default: ;
        endcase
        if (we_req && funct3[2])                         acc_err = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])             acc_err = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)  acc_err = 1'b1;
        if (CHECK_RANGE && ({2'b00, addr[31:2]} >= MEM_WORDS)) acc_err = 1'b1;
    end

    // State register and latched request/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rq_q    <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: sub-word stores need the old word before merging.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err)                                state_d = S_ERR;
                    else if (we_req && funct3[1:0] == 2'b10)    state_d = S_WRITE;
                    else                                        state_d = S_READ;
                end
            end
            S_READ:  state_d = rq_q.we ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane extract from the live read word; captured in READ.
    always_comb begin
        ld_b    = mem_rd[{rq_q.addr[1:0], 3'b000} +: 8];
        ld_h    = mem_rd[{rq_q.addr[1], 4'b0000} +: 16];
        rq_d    = accept ? '{addr: addr, wdata: wdata, f3: funct3, we: we_req} : rq_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        if (state_q == S_READ) begin
            word_d = mem_rd;
            if (!rq_q.we) begin
                case (rq_q.f3)
                    3'b000:  rdata_d = {{24{ld_b[7]}}, ld_b};
                    3'b100:  rdata_d = {24'h0, ld_b};
                    3'b001:  rdata_d = {{16{ld_h[15]}}, ld_h};
                    3'b101:  rdata_d = {16'h0, ld_h};
                    default: rdata_d = mem_rd;
                endcase
            end
        end
    end

    // Merge store data into the word read back in READ.
    always_comb begin
        merged = word_q;
        case (rq_q.f3[1:0])
            2'b00:   merged[{rq_q.addr[1:0], 3'b000} +: 8] = rq_q.wdata[7:0];
            2'b01:   merged[{rq_q.addr[1], 4'b0000} +: 16] = rq_q.wdata[15:0];
            default: merged = rq_q.wdata;
        endcase
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE) || (state_q == S_ERR);
        err      = (state_q == S_ERR);
        mem_we   = (state_q == S_WRITE);
        mem_wd   = (state_q == S_WRITE) ? merged : 32'h0;
        mem_addr = {rq_q.addr[31:2], 2'b00};
        rdata    = rdata_q;
    end

endmodule
